fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the single-issue MIPS-style core. It holds the fetch PC, drives an external synchronous instruction ROM, and buffers returned words in a small FIFO. It presents them to decode through a valid/ready handshake. Decode redirects the stream with register, sign-extended branch, or jump targets, and the redirect flushes all wrong-path words.

## Interface
Parameters:
- XLEN, 32: PC/data width, ≥32.
- ROM_AW, 6: ROM word-address width (depth 2^ROM_AW words).
- BUF_DEPTH, 2: instruction FIFO entries, ≥2.
- RESET_PC, 0: PC loaded on reset, word aligned.

Ports:
- clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- rom_en  out  1  ROM read request this cycle.
- rom_addr  out  ROM_AW  word index = pc[ROM_AW+1:2].
- rom_data  in  32  ROM word, valid the cycle after rom_en.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_code  out  32  head instruction.
- inst_pc4  out  XLEN  head instruction address + 4.
- redir_valid  in  1  redirect request.
- redir_sel  in  2  01 register, 10 branch, 11 jump, 00 none.
- redir_pc4  in  XLEN  pc4 of the redirecting instruction.
- redir_reg  in  XLEN  register target.
- redir_imm  in  16  branch offset in words.
- redir_addr  in  26  jump field.
- misalign  out  1  one-cycle pulse when a register target has bits [1:0] ≠ 0.

## Operation
- Target computation:
  - 01 → redir_reg with bits [1:0] forced to 0.
  - 10 → redir_pc4 + (sext(redir_imm) << 2), modulo 2^XLEN.
  - 11 → {redir_pc4[XLEN-1:28], redir_addr, 2'b00}.
- An effective redirect requires redir_valid=1 and redir_sel≠00. redir_valid with sel 00 is ignored.
- Issue rule: rom_en=1 when count + inflight − pop < BUF_DEPTH and no effective redirect this cycle. Here pop = inst_valid & inst_ready. On issue, pc ← pc+4. inflight is 1 bit.
- Response: the cycle after issue, rom_data and its pc+4 are written at the FIFO tail.
- Redirect: pc ← target. The FIFO is emptied. The in-flight response is discarded next cycle. A concurrent pop is absorbed by the flush.
- Wrap-around: ROM index uses the low bits only; addresses beyond the depth alias. pc wraps modulo 2^XLEN.
- Reset mid-operation: FIFO, inflight and pending responses are dropped; pc ← RESET_PC.
- Reset values: rom_en=0, rom_addr=RESET_PC[ROM_AW+1:2], inst_valid=0, inst_code=0, inst_pc4=0, misalign=0.

## Timing
- Reset released before edge E0: first issue in the cycle after E0. inst_valid rises two cycles after that issue.
- Redirect sampled at edge T: pc=target during T+1, issued in T+1, data in T+2, inst_valid high in T+3 (3-cycle bubble).
- Steady state with inst_ready held at 1: one instruction per cycle, no bubbles, for BUF_DEPTH ≥ 2.
- inst_ready low: the FIFO fills and rom_en drops. No word is lost or duplicated. Outputs hold stable while inst_valid & !inst_ready.
- FIFO full plus in-flight response: impossible by the issue rule. An assertion in the bench checks it.
- misalign is asserted in the cycle after the redirect edge.

## Structure
- Package fetch_pkg:
  - PC_SEL_NONE/REG/BRANCH/JUMP 2-bit constants.
  - Helper function computing the target from sel, pc4, reg, imm and addr.
- Sub-module fetch_fifo (parameter WIDTH=32+XLEN, DEPTH=BUF_DEPTH):
  - Circular buffer with wrapping pointers and count.
  - push/pop/flush, full/empty.
  - Flush has priority over push and pop.
- fetch_unit contains the pc register, issue/inflight logic, target mux, and the ROM ports.

## Test plan
- Reset, RESET_PC=0, ROM[i]=0x1000_0000+i, inst_ready=1 → inst_code 0x10000000, 0x10000001, … on consecutive cycles; inst_pc4 = 4, 8, 12, ….
- inst_ready low for 5 cycles mid-stream → rom_en drops after the FIFO fills; resumed stream has no gaps or repeats.
- Branch redir_pc4=0x20, redir_imm=0xFFFE → next delivered inst_pc4=0x1C (target 0x18), 3-cycle bubble; wrong-path words are never valid.
- Jump redir_pc4=0xF000_0010, redir_addr=0x0000040 → target 0xF000_0100; rom_addr=0x00 for ROM_AW=6 (aliasing).
- Register redirect to 0x0000_0013 → target 0x10, misalign pulses one cycle.
- Redirect in the same cycle as a pop, and rst asserted while inflight=1 → FIFO empty, stale response dropped, restart at the target or RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the redirect-target helper for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [1:0] PC_SEL_NONE   = 2'b00;
    localparam logic [1:0] PC_SEL_REG    = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b11;

    // Target arithmetic is done at 64 bits; callers zero-extend their XLEN
    // operands in and truncate the result back to XLEN. Truncation makes the
    // branch sum wrap modulo 2^XLEN. It also keeps the jump's upper bits
    // equal to pc4[XLEN-1:28].
    function automatic logic [63:0] calc_target(
        input logic [1:0]  sel,
        input logic [63:0] pc4,
        input logic [63:0] reg_tgt,
        input logic [15:0] imm,
        input logic [25:0] addr
    );
        logic [63:0] tgt;
        tgt = pc4;
        case (sel)
            PC_SEL_REG:    tgt = {reg_tgt[63:2], 2'b00};
            PC_SEL_BRANCH: tgt = pc4 + {{46{imm[15]}}, imm, 2'b00};
            PC_SEL_JUMP:   tgt = {pc4[63:28], addr, 2'b00};
            default:       tgt = pc4;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer between the ROM response and decode.
// Flush has priority over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; only entries below count are
        // ever read, so clearing it would add reset fan-out for nothing.
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM request/issue control, redirect target mux
// and the decode-facing instruction buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ROM_AW    = 6,
    parameter int              BUF_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_code,
    output logic [XLEN-1:0]   inst_pc4,
    input  logic              redir_valid,
    input  logic [1:0]        redir_sel,
    input  logic [XLEN-1:0]   redir_pc4,
    input  logic [XLEN-1:0]   redir_reg,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_addr,
    output logic              misalign
);

    localparam int FW = 32 + XLEN;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic            run_q;
    logic            inflight_q;
    logic            misalign_q;
    logic            eff_redir;
    logic            pop;
    logic            issue;
    logic [XLEN-1:0] target;
    logic [FW-1:0]   head;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;

    assign eff_redir = redir_valid && (redir_sel != PC_SEL_NONE);
    assign pop       = inst_valid && inst_ready;
    assign target    = XLEN'(calc_target(redir_sel, 64'(redir_pc4), 64'(redir_reg),
                                         redir_imm, redir_addr));

    // Issue a ROM read only when the buffer can take the reply; a redirect
    // cycle never issues because its PC is already wrong-path.
    always_comb begin
        int occupancy;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        issue     = 1'b0;
        occupancy = int'(fifo_count) + int'(inflight_q) - int'(pop);
        if (run_q && !eff_redir && (occupancy < BUF_DEPTH) && !(fifo_full && !pop))
            issue = 1'b1;
    end

    // PC, start-up, in-flight and misalign state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= issue;
            misalign_q <= eff_redir && (redir_sel == PC_SEL_REG) && (redir_reg[1:0] != 2'b00);
            if (eff_redir)  pc_q <= target;
            else if (issue) pc_q <= pc_q + XLEN'(4);
        end
    end

    // The reply's pc4 equals pc_q: pc advanced by 4 when the word was issued,
    // and any redirect since then also flushes the reply.
    fetch_fifo #(
        .WIDTH(FW),
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (inflight_q),
        .pop    (pop),
        .flush  (eff_redir),
        .wr_data({rom_data, pc_q}),
        .rd_data(head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assign rom_en     = issue;
    assign rom_addr   = pc_q[ROM_AW+1:2];
    assign inst_valid = !fifo_empty;
    assign inst_code  = fifo_empty ? 32'h0 : head[FW-1:XLEN];
    assign inst_pc4   = fifo_empty ? '0 : head[XLEN-1:0];
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, stream scoreboard and
// scenario tasks for reset, streaming, stalls and the three redirect kinds.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          ROM_AW   = 6;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_code;
    logic [31:0] inst_pc4;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_sel = 2'b00;
    logic [31:0] redir_pc4 = 32'h0;
    logic [31:0] redir_reg = 32'h0;
    logic [15:0] redir_imm = 16'h0;
    logic [25:0] redir_addr = 26'h0;
    logic        misalign;

    int vectors = 0;
    int errors  = 0;

    fetch_unit #(.XLEN(XLEN), .ROM_AW(ROM_AW), .BUF_DEPTH(2), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_code(inst_code),
        .inst_pc4(inst_pc4), .redir_valid(redir_valid), .redir_sel(redir_sel),
        .redir_pc4(redir_pc4), .redir_reg(redir_reg), .redir_imm(redir_imm),
        .redir_addr(redir_addr), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: ROM[i] = 0x1000_0000 + i.
    logic [31:0] rom [64];
    initial for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    // Reference word at a byte address, aliasing to the 64-word ROM.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + ((a >> 2) & 32'h3F);
    endfunction

    // Reference redirect target from the architectural rules.
    function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] pc4,
                                                 input logic [31:0] r, input logic [15:0] imm,
                                                 input logic [25:0] a);
        int off;
        off = int'($signed(imm)) * 4;
        case (sel)
            2'b01:   return r & 32'hFFFF_FFFC;
            2'b10:   return pc4 + 32'(off);
            2'b11:   return (pc4 & 32'hF000_0000) | (32'(a) << 2);
            default: return pc4;
        endcase
    endfunction

    // Stream scoreboard: every accepted word must be the next sequential word
    // of the current stream; redirects restart the stream at the target.
    logic [31:0] exp_pc = RESET_PC;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_code, prev_pc4;
    always @(negedge clk) begin
        logic redir_eff;
        if (rst) begin
            exp_pc    = RESET_PC;
            hold_prev = 1'b0;
        end else begin
            redir_eff = redir_valid && (redir_sel != 2'b00);
            if (hold_prev) begin
                vectors++;
                if (!inst_valid || inst_code !== prev_code || inst_pc4 !== prev_pc4) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b code=%h pc4=%h want v=1 code=%h pc4=%h",
                             inst_valid, inst_code, inst_pc4, prev_code, prev_pc4);
                end
            end
            if (redir_eff) begin
                exp_pc = model_target(redir_sel, redir_pc4, redir_reg, redir_imm, redir_addr);
            end else if (inst_valid && inst_ready) begin
                vectors++;
                if (inst_pc4 !== exp_pc + 32'd4 || inst_code !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL stream: got code=%h pc4=%h want code=%h pc4=%h",
                             inst_code, inst_pc4, rom_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            hold_prev = inst_valid && !inst_ready && !redir_eff;
            prev_code = inst_code;
            prev_pc4  = inst_pc4;
            vectors++;
            if (dut.fifo_full && dut.inflight_q) begin
                errors++;
                $display("FAIL full_and_inflight: got full=1 inflight=1 want not both");
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_redir();
        redir_valid = 1'b0;
        redir_sel   = 2'($urandom_range(0, 3));
        redir_pc4   = $urandom;
        redir_reg   = $urandom;
        redir_imm   = 16'($urandom);
        redir_addr  = 26'($urandom);
    endtask

    // After reset release before edge E0: issue after E0, word valid two cycles later.
    task automatic check_restart(input string name);
        cyc();
        @(negedge clk);
        vectors++;
        if (rom_en !== 1'b1 || rom_addr !== RESET_PC[7:2] || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_first_issue: got en=%b addr=%h v=%b want en=1 addr=%h v=0",
                     name, rom_en, rom_addr, inst_valid, RESET_PC[7:2]);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap: got v=%b want v=0", name, inst_valid);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc4 !== RESET_PC + 32'd4 || inst_code !== rom_word(RESET_PC)) begin
            errors++;
            $display("FAIL %s_first_word: got v=%b code=%h pc4=%h want v=1 code=%h pc4=%h",
                     name, inst_valid, inst_code, inst_pc4, rom_word(RESET_PC), RESET_PC + 32'd4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_ready = 1'b1;
        idle_redir();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rom_en, rom_addr, inst_valid, inst_code, inst_pc4, misalign} !== '0) begin
            errors++;
            $display("FAIL reset_values: got en=%b addr=%h v=%b code=%h pc4=%h mis=%b want all 0",
                     rom_en, rom_addr, inst_valid, inst_code, inst_pc4, misalign);
        end
        #1 rst = 1'b0;
        check_restart("reset");
    endtask

    task automatic test_stream(input int n);
        inst_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            idle_redir();
            @(negedge clk);
            vectors++;
            if (inst_valid !== 1'b1 || rom_en !== 1'b1) begin
                errors++;
                $display("FAIL stream_no_bubble[%0d]: got v=%b en=%b want v=1 en=1", i, inst_valid, rom_en);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            cyc();
            inst_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if (inst_valid !== 1'b1 || (i >= 2 && rom_en !== 1'b0)) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b en=%b want v=1 en=0", i, inst_valid, rom_en);
            end
        end
        test_stream(8);
        for (int i = 0; i < 60; i++) begin
            cyc();
            inst_ready = 1'($urandom_range(0, 1));
            idle_redir();
        end
        test_stream(3);
    endtask

    task automatic do_redirect(input string name, input logic [1:0] sel, input logic [31:0] pc4,
                               input logic [31:0] r, input logic [15:0] imm, input logic [25:0] a);
        logic [31:0] tgt;
        logic        exp_mis;
        tgt     = model_target(sel, pc4, r, imm, a);
        exp_mis = (sel == 2'b01) && (r[1:0] != 2'b00);
        cyc();
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_sel   = sel;
        redir_pc4   = pc4;
        redir_reg   = r;
        redir_imm   = imm;
        redir_addr  = a;
        @(negedge clk);
        vectors++;
        if (rom_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_issue: got en=%b want en=0", name, rom_en);
        end
        cyc();
        idle_redir();
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== tgt[7:2] || misalign !== exp_mis) begin
            errors++;
            $display("FAIL %s_t1: got v=%b en=%b addr=%h mis=%b want v=0 en=1 addr=%h mis=%b",
                     name, inst_valid, rom_en, rom_addr, misalign, tgt[7:2], exp_mis);
        end
        cyc();
        idle_redir();
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL %s_t2: got v=%b mis=%b want v=0 mis=0", name, inst_valid, misalign);
        end
        cyc();
        idle_redir();
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc4 !== tgt + 32'd4 || inst_code !== rom_word(tgt)) begin
            errors++;
            $display("FAIL %s_t3: got v=%b code=%h pc4=%h want v=1 code=%h pc4=%h",
                     name, inst_valid, inst_code, inst_pc4, rom_word(tgt), tgt + 32'd4);
        end
    endtask

    task automatic test_branch();
        test_stream(4);
        do_redirect("branch", 2'b10, 32'h20, $urandom, 16'hFFFE, 26'($urandom));
    endtask

    task automatic test_jump();
        test_stream(3);
        do_redirect("jump", 2'b11, 32'hF000_0010, $urandom, 16'($urandom), 26'h0000040);
        test_stream(4);
    endtask

    task automatic test_register();
        do_redirect("register", 2'b01, $urandom, 32'h0000_0013, 16'($urandom), 26'($urandom));
        test_stream(3);
    endtask

    task automatic test_ignored_sel();
        cyc();
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_sel   = 2'b00;
        @(negedge clk);
        vectors++;
        if (rom_en !== 1'b1 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL ignored_sel: got en=%b v=%b want en=1 v=1", rom_en, inst_valid);
        end
        test_stream(4);
    endtask

    // Redirects while the head is being popped, with random stalls between.
    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
                cyc();
                inst_ready = 1'($urandom_range(0, 1));
                idle_redir();
            end
            test_stream(2);
            do_redirect("random_redirect", 2'($urandom_range(1, 3)), $urandom, $urandom,
                        16'($urandom), 26'($urandom));
        end
        test_stream(3);
    endtask

    task automatic test_reset_inflight();
        test_stream(4);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || rom_en !== 1'b0 || inst_code !== 32'h0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight_async: got v=%b en=%b code=%h mis=%b want all 0",
                     inst_valid, rom_en, inst_code, misalign);
        end
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        check_restart("reset_inflight");
        test_stream(5);
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: got no completion want completion within 200000");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_stream(20);
        test_stall();
        test_branch();
        test_jump();
        test_register();
        test_ignored_sel();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
